// File: rtl/rpcd_pkg.sv
// Shared types and constants for the response return-path router.
package rpcd_pkg;
  localparam int CH_DEF    = 8;
  localparam int DEPTH_DEF = 16;
  localparam int DW_DEF    = 64;
  localparam int CH_W      = $clog2(CH_DEF);

  typedef logic [CH_W-1:0] chan_t;
  typedef enum logic {OS_EMPTY, OS_HOLD} os_t;

  localparam int ERR_FULL   = 0;
  localparam int ERR_ORPHAN = 1;
endpackage

// File: rtl/rpcd_tag_fifo.sv
// In-order tag FIFO: channel of each issued request, popped when its response is accepted.
module rpcd_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= din;
  end

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/rpcd_rsp_route.sv
// Routes in-order slave responses back to the channel that issued them,
// through a one-entry output register with per-channel ready.
module rpcd_rsp_route
  import rpcd_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENA,
  input  logic                     ISSUE,
  input  logic [$clog2(CH)-1:0]    ISSUE_TAG,
  output logic                     ISSUE_RDY,
  input  logic                     RSP_VLD,
  input  logic [DW-1:0]            RSP_DATA,
  output logic                     RSP_RDY,
  output logic [CH-1:0]            OUT_VLD,
  output logic [DW-1:0]            OUT_DATA,
  input  logic [CH-1:0]            OUT_RDY,
  output logic [$clog2(DEPTH):0]   PEND,
  output logic [1:0]               ERR,
  input  logic                     ERR_CLR
);
  localparam int CW = $clog2(CH);

  os_t           os_q, os_d;
  logic [CW-1:0] out_tag, head;
  logic [DW-1:0] out_data;
  logic          full, empty, push, pop, drain, rsp_rdy;

  assign push = ENA & ISSUE & ~full;
  assign pop  = RSP_VLD & rsp_rdy;

  rpcd_tag_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .din   (ISSUE_TAG),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (PEND)
  );

  // Accept only from registered FIFO state, so a same-cycle issue never bypasses.
  always_comb begin
    os_d    = os_q;
    drain   = 1'b0;
    rsp_rdy = 1'b0;
    case (os_q)
      OS_EMPTY: begin
        rsp_rdy = ENA & ~empty;
        if (RSP_VLD & rsp_rdy) os_d = OS_HOLD;
      end
      OS_HOLD: begin
        drain   = ENA & OUT_RDY[out_tag];
        rsp_rdy = ENA & ~empty & drain;
        if (drain & ~(RSP_VLD & rsp_rdy)) os_d = OS_EMPTY;
      end
      default: os_d = OS_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      os_q     <= OS_EMPTY;
      out_tag  <= '0;
      out_data <= '0;
    end else begin
      os_q <= os_d;
      if (pop) begin
        out_tag  <= head;
        out_data <= RSP_DATA;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ERR <= '0;
    end else if (ERR_CLR) begin
      ERR <= '0;
    end else if (ENA) begin
      if (ISSUE & full)    ERR[ERR_FULL]   <= 1'b1;
      if (RSP_VLD & empty) ERR[ERR_ORPHAN] <= 1'b1;
    end
  end

  for (genvar n = 0; n < CH; n++) begin : g_vld
    assign OUT_VLD[n] = (os_q == OS_HOLD) && (out_tag == CW'(n));
  end

  assign OUT_DATA  = out_data;
  assign RSP_RDY   = rsp_rdy;
  assign ISSUE_RDY = ~full;
endmodule

// File: tb/tb_rpcd_rsp_route.sv
// Bench for rpcd_rsp_route: directed scenarios plus random traffic against a queue-based model.
module tb_rpcd_rsp_route;
  localparam int CH = 8, DEPTH = 16, DW = 64;

  logic          CLK = 1'b0;
  logic          RST, ENA, ISSUE, RSP_VLD, ERR_CLR;
  logic [2:0]    ISSUE_TAG;
  logic [DW-1:0] RSP_DATA;
  logic [CH-1:0] OUT_RDY;
  logic          ISSUE_RDY, RSP_RDY;
  logic [CH-1:0] OUT_VLD;
  logic [DW-1:0] OUT_DATA;
  logic [4:0]    PEND;
  logic [1:0]    ERR;

  rpcd_rsp_route #(.CH(CH), .DEPTH(DEPTH), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .ISSUE(ISSUE), .ISSUE_TAG(ISSUE_TAG),
    .ISSUE_RDY(ISSUE_RDY), .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA), .RSP_RDY(RSP_RDY),
    .OUT_VLD(OUT_VLD), .OUT_DATA(OUT_DATA), .OUT_RDY(OUT_RDY), .PEND(PEND),
    .ERR(ERR), .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  // Reference model: queue of outstanding tags plus the held response.
  int            q[$];
  bit            held;
  int            htag;
  logic [DW-1:0] hdata;
  logic [1:0]    merr;
  int            checks = 0, passes = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rsp_rdy();
    return ENA && (q.size() > 0) && (!held || OUT_RDY[htag]);
  endfunction

  task automatic model_reset();
    q.delete();
    held = 0; htag = 0; hdata = '0; merr = 2'b00;
  endtask

  task automatic model_step();
    bit acc, drn;
    int sz;
    logic [1:0] seterr;
    seterr = 2'b00;
    if (ENA) begin
      sz  = q.size();
      acc = RSP_VLD && exp_rsp_rdy();
      drn = held && OUT_RDY[htag];
      seterr = {RSP_VLD && sz == 0, ISSUE && sz == DEPTH};
      if (acc) begin
        htag = q.pop_front(); held = 1; hdata = RSP_DATA;
      end else if (drn) held = 0;
      if (ISSUE && sz < DEPTH) q.push_back(int'(ISSUE_TAG));
    end
    if (ERR_CLR) merr = 2'b00;
    else merr = merr | seterr;
  endtask

  task automatic check_all(input string p);
    logic [7:0] ev;
    ev = held ? (8'd1 << htag) : 8'd0;
    chk({p, "_issue_rdy"}, 64'(ISSUE_RDY), 64'(q.size() < DEPTH));
    chk({p, "_rsp_rdy"},   64'(RSP_RDY),   64'(exp_rsp_rdy()));
    chk({p, "_out_vld"},   64'(OUT_VLD),   64'(ev));
    chk({p, "_out_data"},  OUT_DATA,       hdata);
    chk({p, "_pend"},      64'(PEND),      64'(q.size()));
    chk({p, "_err"},       64'(ERR),       64'(merr));
  endtask

  // Entered at posedge+1 with inputs set; checks mid-cycle, steps model at the edge.
  task automatic cyc(input string p);
    #3;
    check_all(p);
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle();
    ENA = 1; ISSUE = 0; RSP_VLD = 0; OUT_RDY = '0; ERR_CLR = 0;
  endtask

  initial begin
    int tags[3];
    logic [7:0] ev[3];
    logic [DW-1:0] d[3];
    int n;

    tags = '{3, 5, 0};
    ev   = '{8'h08, 8'h20, 8'h01};
    d    = '{64'hA0A0_0000_0000_000A, 64'hB0B0_0000_0000_000B, 64'hC0C0_0000_0000_000C};

    RST = 0; idle(); ISSUE_TAG = '0; RSP_DATA = '0;
    model_reset();
    #12;
    check_all("reset");
    RST = 1;
    @(posedge CLK); #1;

    // In-order routing
    OUT_RDY = '1;
    for (int i = 0; i < 3; i++) begin
      ISSUE = 1; ISSUE_TAG = 3'(tags[i]); cyc("t2_iss");
    end
    ISSUE = 0;
    chk("t2_pend3", 64'(PEND), 64'd3);
    for (int i = 0; i < 3; i++) begin
      RSP_VLD = 1; RSP_DATA = d[i]; cyc("t2_rsp");
      chk("t2_vld", 64'(OUT_VLD), 64'(ev[i]));
      chk("t2_data", OUT_DATA, d[i]);
    end
    RSP_VLD = 0;
    cyc("t2_drain");
    chk("t2_pend0", 64'(PEND), 64'd0);

    // Backpressure on the held channel
    ISSUE = 1; ISSUE_TAG = 3; cyc("t3_iss");
    ISSUE_TAG = 6; cyc("t3_iss");
    ISSUE = 0; RSP_VLD = 1; RSP_DATA = 64'h1111; cyc("t3_ld");
    OUT_RDY = 8'hF7; RSP_DATA = 64'h2222; #1;
    chk("t3_stall_rdy", 64'(RSP_RDY), 64'd0);
    cyc("t3_stall"); cyc("t3_stall");
    chk("t3_hold_vld", 64'(OUT_VLD), 64'h08);
    OUT_RDY = '1; #1;
    chk("t3_rdy", 64'(RSP_RDY), 64'd1);
    cyc("t3_reload");
    chk("t3_new_vld", 64'(OUT_VLD), 64'h40);
    chk("t3_new_data", OUT_DATA, 64'h2222);
    RSP_VLD = 0; cyc("t3_drain");

    // Full FIFO and overflow
    OUT_RDY = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ISSUE = 1; ISSUE_TAG = 3'($urandom_range(0, 7)); cyc("t4_fill");
    end
    chk("t4_full_rdy", 64'(ISSUE_RDY), 64'd0);
    chk("t4_pend16", 64'(PEND), 64'd16);
    cyc("t4_ovf");
    chk("t4_err", 64'(ERR), 64'b01);
    chk("t4_pend_ovf", 64'(PEND), 64'd16);
    ISSUE = 0; ERR_CLR = 1; cyc("t4_clr");
    ERR_CLR = 0; RSP_VLD = 1; RSP_DATA = 64'h3333; cyc("t4_pop");
    chk("t4_pend15", 64'(PEND), 64'd15);
    OUT_RDY = '1; ISSUE = 1; ISSUE_TAG = 1; RSP_DATA = 64'h4444; cyc("t4_pushpop");
    chk("t4_pend_same", 64'(PEND), 64'd15);

    // Orphan response
    ISSUE = 0; n = 0;
    while (q.size() > 0 && n < 40) begin
      RSP_DATA = {$urandom, $urandom}; cyc("t5_drain"); n++;
    end
    chk("t5_drained", 64'(PEND), 64'd0);
    #1;
    chk("t5_orphan_rdy", 64'(RSP_RDY), 64'd0);
    cyc("t5_orphan");
    chk("t5_err1", 64'(ERR[1]), 64'd1);
    ERR_CLR = 1; cyc("t5_clr");
    chk("t5_err_clr", 64'(ERR), 64'd0);
    ERR_CLR = 0; RSP_VLD = 0; cyc("t5_idle");

    // Enable low freezes everything
    OUT_RDY = '0; ISSUE = 1; ISSUE_TAG = 2; cyc("t6_iss");
    ISSUE_TAG = 7; RSP_VLD = 1; RSP_DATA = 64'h5555; cyc("t6_ld");
    ENA = 0; ISSUE = 1; RSP_VLD = 1; OUT_RDY = '1; RSP_DATA = 64'h6666;
    for (int i = 0; i < 3; i++) cyc("t6_frozen");
    chk("t6_pend", 64'(PEND), 64'd1);
    chk("t6_vld", 64'(OUT_VLD), 64'h04);
    chk("t6_data", OUT_DATA, 64'h5555);
    chk("t6_err", 64'(ERR), 64'd0);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ENA       = ($urandom % 10) != 0;
      ISSUE     = ((i / 50) % 2 == 0) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      ISSUE_TAG = 3'($urandom);
      RSP_VLD   = ($urandom % 3) != 0;
      RSP_DATA  = {$urandom, $urandom};
      OUT_RDY   = 8'($urandom) | 8'($urandom);
      ERR_CLR   = ($urandom % 20) == 0;
      cyc("rnd");
    end

    // Reset mid-traffic
    ENA = 1; ISSUE = 1; ISSUE_TAG = 4; RSP_VLD = 0; OUT_RDY = '0; ERR_CLR = 0;
    cyc("t1_pre"); cyc("t1_pre");
    RSP_VLD = 1; cyc("t1_pre");
    idle();
    #2 RST = 0;
    #1;
    chk("t1_vld", 64'(OUT_VLD), 64'd0);
    chk("t1_data", OUT_DATA, 64'd0);
    chk("t1_rsp_rdy", 64'(RSP_RDY), 64'd0);
    chk("t1_issue_rdy", 64'(ISSUE_RDY), 64'd1);
    chk("t1_pend", 64'(PEND), 64'd0);
    chk("t1_err", 64'(ERR), 64'd0);
    model_reset();
    @(negedge CLK); RST = 1;
    @(posedge CLK); #1;
    cyc("t1_post");
    chk("t1_pend_post", 64'(PEND), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
